// File: rtl/hv_abist_seq.sv
// HV-side BIST sequencer: ABIST enable/complete handshake, then LBIST verdict, then a sticky result.
// Latency: req->o_bist_en 1 cycle, i_lbist_done->o_bist_done 1 cycle; no backpressure; every phase is watchdog-bounded.
module hv_abist_seq #(
    parameter int CLK_M          = 48,
    parameter int ABIST_TMO_US   = 100,
    parameter int LBIST_TMO_US   = 200,
    parameter int ABIST_ITEM_NUM = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_bist_req,
    input  logic                      i_bist_abort,
    output logic                      o_bist_en,
    input  logic                      i_lbist_en,
    input  logic [ABIST_ITEM_NUM-1:0] i_abist_status,
    input  logic                      i_lbist_done,
    input  logic                      i_lbist_pass,
    output logic                      o_bist_busy,
    output logic                      o_bist_done,
    output logic                      o_bist_fail,
    output logic [ABIST_ITEM_NUM+1:0] o_bist_result
);
    localparam int ABIST_TMO_CYC = ABIST_TMO_US * CLK_M;
    localparam int LBIST_TMO_CYC = LBIST_TMO_US * CLK_M;
    localparam int MAX_CYC       = (ABIST_TMO_CYC > LBIST_TMO_CYC) ? ABIST_TMO_CYC : LBIST_TMO_CYC;
    localparam int CW            = $clog2(MAX_CYC + 1);
    localparam int RW            = ABIST_ITEM_NUM + 2;
    localparam int TMO_BIT       = ABIST_ITEM_NUM;
    localparam int LB_BIT        = ABIST_ITEM_NUM + 1;

    localparam logic [CW-1:0] ABIST_LAST = CW'(ABIST_TMO_CYC - 1);
    localparam logic [CW-1:0] LBIST_LAST = CW'(LBIST_TMO_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABIST = 2'd1,
        LBIST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic            en_nxt, busy_nxt, done_nxt, fail_nxt, go_done;
    logic [RW-1:0]   res_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            o_bist_en     <= 1'b0;
            o_bist_busy   <= 1'b0;
            o_bist_done   <= 1'b0;
            o_bist_fail   <= 1'b0;
            o_bist_result <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            o_bist_en     <= en_nxt;
            o_bist_busy   <= busy_nxt;
            o_bist_done   <= done_nxt;
            o_bist_fail   <= fail_nxt;
            o_bist_result <= res_nxt;
        end
    end

    // Saturating so a stuck phase can never wrap back below its timeout compare.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        en_nxt    = o_bist_en;
        busy_nxt  = o_bist_busy;
        done_nxt  = 1'b0;
        fail_nxt  = o_bist_fail;
        res_nxt   = o_bist_result;
        go_done   = 1'b0;

        if (i_bist_abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            en_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            fail_nxt  = 1'b0;
            res_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_bist_req) begin
                        state_nxt = ABIST;
                        cnt_nxt   = '0;
                        en_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        fail_nxt  = 1'b0;
                        res_nxt   = '0;
                    end
                end
                ABIST: begin
                    cnt_nxt = cnt_inc;
                    // o_bist_en is kept high into LBIST: dropping it clears the engine's completion flag.
                    if (i_lbist_en) begin
                        res_nxt[ABIST_ITEM_NUM-1:0] = i_abist_status;
                        cnt_nxt   = '0;
                        state_nxt = LBIST;
                    end else if (cnt == ABIST_LAST) begin
                        res_nxt[TMO_BIT] = 1'b1;
                        go_done          = 1'b1;
                    end
                end
                LBIST: begin
                    cnt_nxt = cnt_inc;
                    if (i_lbist_done) begin
                        res_nxt[LB_BIT] = ~i_lbist_pass;
                        go_done         = 1'b1;
                    end else if (cnt == LBIST_LAST) begin
                        res_nxt[TMO_BIT] = 1'b1;
                        res_nxt[LB_BIT]  = 1'b1;
                        go_done          = 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (go_done) begin
                state_nxt = DONE;
                cnt_nxt   = '0;
                en_nxt    = 1'b0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                fail_nxt  = |res_nxt;
            end
        end
    end

endmodule

// File: tb/tb_hv_abist_seq.sv
module tb_hv_abist_seq;
    localparam int ATMO = 4800;
    localparam int LTMO = 9600;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       req = 1'b0, abort = 1'b0, lbist_en = 1'b0, lbist_done = 1'b0, lbist_pass = 1'b0;
    logic [5:0] status = '0;
    logic       o_bist_en, o_bist_busy, o_bist_done, o_bist_fail;
    logic [7:0] o_bist_result;

    hv_abist_seq #(.CLK_M(48), .ABIST_TMO_US(100), .LBIST_TMO_US(200), .ABIST_ITEM_NUM(6)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_bist_req(req), .i_bist_abort(abort),
        .o_bist_en(o_bist_en), .i_lbist_en(lbist_en), .i_abist_status(status),
        .i_lbist_done(lbist_done), .i_lbist_pass(lbist_pass), .o_bist_busy(o_bist_busy),
        .o_bist_done(o_bist_done), .o_bist_fail(o_bist_fail), .o_bist_result(o_bist_result)
    );

    always #5 i_clk = ~i_clk;

    int         total = 0, bad = 0, done_cnt = 0, en_cycles = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse pops one expected {fail,result}.
    always @(negedge i_clk) begin
        if (o_bist_en) en_cycles++;
        if (o_bist_done) begin
            done_cnt++;
            check("en_low_in_done", {o_bist_en, o_bist_busy}, 2'b00);
            if (exp_q.size() == 0) begin
                check("spurious_done", exp_q.size(), 1);
            end else begin
                exp_e = exp_q.pop_front();
                check("result", o_bist_result, exp_e[7:0]);
                check("fail", o_bist_fail, exp_e[8]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [7:0] res);
        exp_q.push_back({|res, res});
    endtask

    task automatic start();
        en_cycles = 0;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        check("req_to_en", {o_bist_en, o_bist_busy, o_bist_fail, o_bist_result}, 11'b110_0000_0000);
    endtask

    task automatic wait_done(input int budget, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge i_clk);
            #1;
            k++;
        end
        check("done_seen", done_cnt, d0 + 1);
    endtask

    // na: ABIST cycles before i_lbist_en; nl: LBIST cycles before i_lbist_done (nl<0: never).
    task automatic run_seq(input string tag, input int na, input logic [5:0] st, input int nl, input logic pass);
        int d0;
        logic [7:0] res;
        d0  = done_cnt;
        res = (nl < 0) ? {2'b11, st} : {~pass, 1'b0, st};
        push_exp(res);
        start();
        tick(na);
        lbist_en = 1'b1;
        status   = st;
        tick(1);
        if (nl >= 0) begin
            tick(nl);
            lbist_done = 1'b1;
            lbist_pass = pass;
            tick(1);
            lbist_done = 1'b0;
            wait_done(5, d0);
            check({tag, "_en_cycles"}, en_cycles, na + nl + 2);
        end else begin
            wait_done(LTMO + 20, d0);
            check({tag, "_en_cycles"}, en_cycles, na + 1 + LTMO);
        end
        lbist_en = 1'b0;
        status   = '0;
        tick(3);
        check({tag, "_hold"}, {o_bist_busy, o_bist_fail, o_bist_result}, {1'b0, |res, res});
    endtask

    initial begin
        int d0;
        #3;
        check("reset_state", {o_bist_en, o_bist_busy, o_bist_done, o_bist_fail, o_bist_result}, 12'h000);
        tick(2);
        i_rst = 1'b0;
        tick(2);

        run_seq("nominal", 3749, 6'b000000, 9, 1'b1);
        run_seq("item_fail", 3749, 6'b001000, 9, 1'b1);

        // ABIST timeout: engine never completes
        d0 = done_cnt;
        push_exp(8'h40);
        start();
        wait_done(ATMO + 20, d0);
        check("abist_tmo_cycles", en_cycles, ATMO);
        tick(3);
        check("abist_tmo_hold", o_bist_result, 8'h40);

        run_seq("abist_boundary", ATMO - 1, 6'b000000, 4, 1'b1);
        run_seq("lbist_fail", 20, 6'b000000, 7, 1'b0);
        run_seq("lbist_tmo", 15, 6'b000000, -1, 1'b1);

        // Abort while idle clears the held result
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_idle_clear", {o_bist_fail, o_bist_result}, 9'h000);

        // Abort during LBIST
        d0 = done_cnt;
        start();
        tick(5);
        lbist_en = 1'b1;
        status   = 6'b000101;
        tick(4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        lbist_en = 1'b0;
        status   = '0;
        check("abort_lbist", {o_bist_en, o_bist_busy, o_bist_fail, o_bist_result}, 11'h000);
        tick(20);
        check("abort_no_done", done_cnt, d0);

        // Asynchronous reset mid-ABIST
        d0 = done_cnt;
        start();
        tick(100);
        i_rst = 1'b1;
        #1;
        check("rst_mid_abist", {o_bist_en, o_bist_busy, o_bist_done, o_bist_fail, o_bist_result}, 12'h000);
        tick(2);
        i_rst = 1'b0;
        tick(20);
        check("rst_no_done", done_cnt, d0);

        // Second request while busy is neither honoured nor queued
        d0 = done_cnt;
        push_exp(8'h01);
        start();
        tick(10);
        req = 1'b1;
        tick(3);
        req = 1'b0;
        lbist_en = 1'b1;
        status   = 6'b000001;
        tick(1);
        req = 1'b1;
        tick(2);
        req = 1'b0;
        lbist_done = 1'b1;
        lbist_pass = 1'b1;
        tick(1);
        lbist_done = 1'b0;
        lbist_en   = 1'b0;
        status     = '0;
        tick(30);
        check("busy_req_one_done", done_cnt, d0 + 1);
        check("busy_req_not_queued", {o_bist_en, o_bist_busy}, 2'b00);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hv_abist_seq.md
Name: hv_abist_seq

Overview:
- BIST sequencer on the HV digital side. It is the initiator of the analog-BIST handshake.
- On a request it drives the ABIST enable and waits for the ABIST engine to report completion. It then samples the six per-item status bits and hands over to logic BIST.
- It waits for the LBIST verdict and then publishes a sticky result vector with a done pulse and a fail flag.
- Each phase has its own timeout watchdog so the sequence always terminates.

Parameters:
- CLK_M, 48, clock frequency in MHz; cycles per microsecond.
- ABIST_TMO_US, 100, ABIST phase timeout in microseconds (covers the 70+4x1+4 us item budget plus margin).
- LBIST_TMO_US, 200, LBIST phase timeout in microseconds.
- ABIST_ITEM_NUM, 6, number of analog BIST items (ov, ot, opscod, oc, sc, adc).

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, reset; asynchronous, active-high. One clock domain only.
- i_bist_req, input, 1, start request; sampled only in IDLE.
- i_bist_abort, input, 1, abort the sequence; highest priority.
- o_bist_en, output, 1, ABIST enable to the ABIST engine.
- i_lbist_en, input, 1, ABIST-complete indication from the ABIST engine (level).
- i_abist_status, input, ABIST_ITEM_NUM, per-item status; 1 = item not detected (fail), 0 = pass. Bit order: ov, ot, opscod, oc, sc, adc (bit0 = ov).
- i_lbist_done, input, 1, LBIST finished (level or pulse).
- i_lbist_pass, input, 1, LBIST verdict; valid when i_lbist_done=1.
- o_bist_busy, output, 1, high in ABIST or LBIST state.
- o_bist_done, output, 1, one-cycle completion pulse.
- o_bist_fail, output, 1, OR of o_bist_result; sticky.
- o_bist_result, output, ABIST_ITEM_NUM+2, result vector:
  - [ABIST_ITEM_NUM-1:0] = captured ABIST status.
  - [ABIST_ITEM_NUM] = timeout flag.
  - [ABIST_ITEM_NUM+1] = LBIST fail.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0.
- Timeout constants:
  - ABIST_TMO_CYC = ABIST_TMO_US*CLK_M.
  - LBIST_TMO_CYC = LBIST_TMO_US*CLK_M.
  - Counter width = clog2(max(ABIST_TMO_CYC, LBIST_TMO_CYC)+1).
  - The counter saturates and never wraps.
- States: IDLE, ABIST, LBIST, DONE. All outputs are registered.
- IDLE:
  - If i_bist_req=1 (and i_bist_abort=0), go to ABIST next cycle.
  - At that edge: o_bist_en=1, o_bist_busy=1, o_bist_result cleared to 0, o_bist_fail cleared to 0, counter = 0.
- ABIST (counter increments by 1 per cycle):
  - If i_lbist_en=1: capture i_abist_status into result[ABIST_ITEM_NUM-1:0], counter = 0, go to LBIST. o_bist_en stays 1, because dropping it would clear the engine's completion flag.
  - Else if counter = ABIST_TMO_CYC-1: set result[ABIST_ITEM_NUM]=1, go to DONE. Status bits are not captured and stay 0.
  - If i_lbist_en and the timeout occur in the same cycle, i_lbist_en wins and no timeout is flagged.
- LBIST:
  - If i_lbist_done=1: result[ABIST_ITEM_NUM+1] = ~i_lbist_pass, go to DONE.
  - Else if counter = LBIST_TMO_CYC-1: set result[ABIST_ITEM_NUM]=1 and result[ABIST_ITEM_NUM+1]=1, go to DONE.
  - If i_lbist_done and the timeout occur in the same cycle, i_lbist_done wins.
- DONE (exactly one cycle):
  - o_bist_en=0, o_bist_busy=0, o_bist_done=1, o_bist_fail = |result.
  - Return to IDLE next cycle; o_bist_done=0 then.
  - i_bist_req in DONE is ignored.
- Request handling:
  - i_bist_req while busy is ignored and not queued.
  - A held-high i_bist_req restarts a sequence on the first IDLE cycle after DONE.
- Abort:
  - i_bist_abort=1 in any state forces IDLE next cycle.
  - Effects: o_bist_en=0, o_bist_busy=0, counter=0, o_bist_result=0, o_bist_fail=0; no o_bist_done pulse.
  - Abort beats req, i_lbist_en and timeout in the same cycle.
- Reset mid-operation: asynchronous return to the reset values; no done pulse.
- Result and fail hold their values from DONE until the next accepted request, abort, or reset.
- Latency: req to o_bist_en = 1 cycle; i_lbist_done to o_bist_done = 1 cycle.

Test Plan (CLK_M=48, so ABIST_TMO_CYC=4800 and LBIST_TMO_CYC=9600):
- Nominal pass: req; i_lbist_en high after 3750 cycles with status=6'b000000; i_lbist_done=1, pass=1 10 cycles later -> o_bist_en high 3760 cycles, one done pulse, result=8'h00, fail=0.
- Item fail: as nominal but status=6'b001000 (oc) -> result=8'h08, fail=1; o_bist_en low in the DONE cycle.
- ABIST timeout: i_lbist_en never asserted -> DONE exactly 4800 cycles after entering ABIST, result=8'h40, fail=1.
- ABIST boundary: i_lbist_en asserted exactly at counter 4799 with status 0, then LBIST pass -> result=8'h00.
- LBIST fail and timeout: i_lbist_done with pass=0 -> result=8'h80. Separately, no i_lbist_done -> after 9600 cycles result=8'hC0.
- Abort/reset/request rules:
  - Abort in LBIST -> o_bist_en=0 next cycle, no done pulse, result=0.
  - i_rst pulse mid-ABIST -> all outputs 0 immediately.
  - Second req while busy -> ignored; exactly one done pulse.
